// File: rtl/lsu_dccm_wbuf_mem.sv
// Banked DCCM data store with an in-order write buffer. Reads own their banks;
// the buffer head drains into any bank left idle, and reads forward from pending entries.
module lsu_dccm_wbuf_mem #(
    parameter int NUM_BANKS  = 8,
    parameter int BANK_DEPTH = 256,
    parameter int DATA_WIDTH = 39,
    parameter int WBUF_DEPTH = 4,
    localparam int BANK_BITS  = $clog2(NUM_BANKS),
    localparam int INDEX_BITS = $clog2(BANK_DEPTH),
    localparam int ADDR_WIDTH = 2 + BANK_BITS + INDEX_BITS,
    localparam int CNT_BITS   = $clog2(WBUF_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  freeze,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr_lo,
    input  logic [ADDR_WIDTH-1:0] rd_addr_hi,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data_lo,
    output logic [DATA_WIDTH-1:0] rd_data_hi,
    output logic [CNT_BITS-1:0]   wbuf_count,
    output logic                  wbuf_empty
);

    localparam int PTR_BITS  = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int WORD_BITS = ADDR_WIDTH - 2;
    localparam logic [PTR_BITS:0]   DEPTH_P = (PTR_BITS + 1)'(WBUF_DEPTH);
    localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(WBUF_DEPTH);

    // Buffer entries hold word addresses only; byte-offset bits never matter.
    logic [WORD_BITS-1:0]  ent_addr_q [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] ent_data_q [WBUF_DEPTH];
    logic [PTR_BITS-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_BITS-1:0]   count_q, count_d;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_lo_q, rd_data_hi_q;

    logic [WORD_BITS-1:0]  word_lo, word_hi, wr_word, head_word;
    logic [BANK_BITS-1:0]  bank_lo, bank_hi, head_bank;
    logic [INDEX_BITS-1:0] idx_lo, idx_hi, head_idx;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  rd_fire, hi_same_bank, head_blocked, drain, enq;
    logic                  unused_byte_bits;

    function automatic logic [PTR_BITS-1:0] ptr_add(input logic [PTR_BITS-1:0] p,
                                                    input logic [PTR_BITS:0]   n);
        logic [PTR_BITS:0] sum;
        sum = {1'b0, p} + n;
        if (sum >= DEPTH_P) sum = sum - DEPTH_P;
        return sum[PTR_BITS-1:0];
    endfunction

    assign word_lo          = rd_addr_lo[ADDR_WIDTH-1:2];
    assign word_hi          = rd_addr_hi[ADDR_WIDTH-1:2];
    assign wr_word          = wr_addr[ADDR_WIDTH-1:2];
    assign unused_byte_bits = ^{rd_addr_lo[1:0], rd_addr_hi[1:0], wr_addr[1:0]};

    assign bank_lo   = word_lo[0 +: BANK_BITS];
    assign bank_hi   = word_hi[0 +: BANK_BITS];
    assign idx_lo    = word_lo[BANK_BITS +: INDEX_BITS];
    assign idx_hi    = word_hi[BANK_BITS +: INDEX_BITS];
    assign head_word = ent_addr_q[head_q];
    assign head_data = ent_data_q[head_q];
    assign head_bank = head_word[0 +: BANK_BITS];
    assign head_idx  = head_word[BANK_BITS +: INDEX_BITS];

    assign rd_fire      = rd_en & ~freeze;
    assign hi_same_bank = (bank_hi == bank_lo);
    assign head_blocked = rd_fire & ((head_bank == bank_lo) | (head_bank == bank_hi));
    assign drain        = ~freeze & (count_q != '0) & ~head_blocked;

    // wr_valid/wr_ready: a write is taken on a cycle where both are high. wr_ready
    // looks only at the registered count (and freeze), so a full buffer refuses
    // even while draining; a refused write is simply not taken and must be held.
    assign wr_ready = ~freeze & (count_q < DEPTH_C);
    assign enq      = wr_valid & wr_ready;

    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : gen_bank
        logic [DATA_WIDTH-1:0] mem_q [BANK_DEPTH];
        logic                  rd_sel, wr_sel, bank_en;
        logic [INDEX_BITS-1:0] rd_index;

        assign rd_sel   = rd_fire & ((bank_lo == BANK_BITS'(b)) | (bank_hi == BANK_BITS'(b)));
        assign wr_sel   = drain & (head_bank == BANK_BITS'(b));
        assign bank_en  = ~freeze & (rd_sel | wr_sel);
        assign rd_index = (bank_lo == BANK_BITS'(b)) ? idx_lo : idx_hi;

        always_ff @(posedge clk) begin
            if (bank_en && wr_sel) mem_q[head_idx] <= head_data;
        end

        assign bank_rdata[b] = mem_q[rd_index];
    end

    // Walk entries oldest to youngest so the youngest matching write wins.
    logic                  fwd_lo_hit, fwd_hi_hit;
    logic [DATA_WIDTH-1:0] fwd_lo_data, fwd_hi_data;
    logic [PTR_BITS-1:0]   slot;

    always_comb begin
        fwd_lo_hit  = 1'b0;
        fwd_hi_hit  = 1'b0;
        fwd_lo_data = '0;
        fwd_hi_data = '0;
        slot        = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (CNT_BITS'(i) < count_q) begin
                slot = ptr_add(head_q, (PTR_BITS + 1)'(i));
                if (ent_addr_q[slot] == word_lo) begin
                    fwd_lo_hit  = 1'b1;
                    fwd_lo_data = ent_data_q[slot];
                end
                if (ent_addr_q[slot] == word_hi) begin
                    fwd_hi_hit  = 1'b1;
                    fwd_hi_data = ent_data_q[slot];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] data_lo, data_hi;

    assign data_lo = fwd_lo_hit ? fwd_lo_data : bank_rdata[bank_lo];
    assign data_hi = hi_same_bank ? data_lo :
                     (fwd_hi_hit ? fwd_hi_data : bank_rdata[bank_hi]);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) head_d = ptr_add(head_q, (PTR_BITS + 1)'(1));
        if (enq)   tail_d = ptr_add(tail_q, (PTR_BITS + 1)'(1));
        case ({enq, drain})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            ent_addr_q[tail_q] <= wr_word;
            ent_data_q[tail_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_lo_q <= '0;
            rd_data_hi_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            // Freeze holds the whole read-data stage.
            if (!freeze) begin
                rd_valid_q <= rd_fire;
                if (rd_fire) begin
                    rd_data_lo_q <= data_lo;
                    rd_data_hi_q <= data_hi;
                end
            end
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data_lo = rd_data_lo_q;
    assign rd_data_hi = rd_data_hi_q;
    assign wbuf_count = count_q;
    assign wbuf_empty = (count_q == '0);

endmodule

// File: tb/tb_lsu_dccm_wbuf_mem.sv
// Bench for lsu_dccm_wbuf_mem: directed scenarios plus random traffic against a
// queue-and-memory reference model.
module tb_lsu_dccm_wbuf_mem;

    localparam int NB = 8;
    localparam int DW = 39;
    localparam int WD = 4;
    localparam int AW = 13;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic          freeze = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr_lo = '0;
    logic [AW-1:0] rd_addr_hi = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data_lo, rd_data_hi;
    logic [CW-1:0] wbuf_count;
    logic          wbuf_empty;

    lsu_dccm_wbuf_mem #(.NUM_BANKS(NB), .BANK_DEPTH(256), .DATA_WIDTH(DW), .WBUF_DEPTH(WD)) dut (
        .clk(clk), .rst_l(rst_l), .freeze(freeze), .rd_en(rd_en),
        .rd_addr_lo(rd_addr_lo), .rd_addr_hi(rd_addr_hi),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data_lo(rd_data_lo), .rd_data_hi(rd_data_hi),
        .wbuf_count(wbuf_count), .wbuf_empty(wbuf_empty)
    );

    always #5 clk = ~clk;

    // Reference model: pending writes in arrival order, plus known memory words.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];
    logic [DW-1:0] mem_m[int];
    logic          exp_valid;
    logic [DW-1:0] exp_lo, exp_hi;
    bit            lo_known, hi_known;
    int            checks = 0;
    int            errors = 0;

    function automatic int word_of(input logic [AW-1:0] a);
        return int'(a) / 4;
    endfunction

    function automatic int bank_of(input logic [AW-1:0] a);
        return (int'(a) / 4) % NB;
    endfunction

    function automatic bit model_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        d = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (word_of(mq[i].addr) == word_of(a)) begin
                d = mq[i].data;
                return 1'b1;
            end
        end
        if (mem_m.exists(word_of(a))) begin
            d = mem_m[word_of(a)];
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        mem_m.delete();
        exp_valid = 1'b0;
        exp_lo    = '0;
        exp_hi    = '0;
        lo_known  = 1'b1;
        hi_known  = 1'b1;
    endtask

    // Driver: called at a negedge, applies inputs for one cycle, advances the model,
    // returns at the following negedge.
    task automatic drive_cycle(input bit f, input bit re, input logic [AW-1:0] lo,
                               input logic [AW-1:0] hi, input bit wv,
                               input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        bit            acc, drn, enq, klo, khi;
        logic [DW-1:0] dlo, dhi;
        int            hb;
        freeze = f; rd_en = re; rd_addr_lo = lo; rd_addr_hi = hi;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        acc = re && !f;
        klo = model_read(lo, dlo);
        if (bank_of(hi) == bank_of(lo)) begin
            dhi = dlo;
            khi = klo;
        end else begin
            khi = model_read(hi, dhi);
        end
        hb  = (mq.size() > 0) ? bank_of(mq[0].addr) : -1;
        drn = !f && (mq.size() > 0) && !(acc && (hb == bank_of(lo) || hb == bank_of(hi)));
        enq = wv && !f && (mq.size() < WD);
        @(posedge clk);
        if (drn) begin
            mem_m[word_of(mq[0].addr)] = mq[0].data;
            void'(mq.pop_front());
        end
        if (enq) mq.push_back(ent_t'{addr: wa, data: wd});
        if (!f) begin
            exp_valid = acc;
            if (acc) begin
                exp_lo = dlo; exp_hi = dhi;
                lo_known = klo; hi_known = khi;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, '0, '0, 0, '0, '0);
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (wbuf_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", wbuf_count); end
        checks++; if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", wbuf_empty); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", wr_ready); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
        checks++; if (rd_data_lo !== '0 || rd_data_hi !== '0) begin
            errors++; $display("FAIL reset_rd_data got %h/%h exp 0/0", rd_data_lo, rd_data_hi);
        end
        model_reset();
        rst_l = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_drain();
        drive_cycle(0, 0, '0, '0, 1, 13'h040, 39'h0AA);
        checks++; if (wbuf_count !== 3'd1) begin errors++; $display("FAIL wd_count_enq got %0d exp 1", wbuf_count); end
        idle(1);
        checks++; if (wbuf_count !== 3'd0 || wbuf_empty !== 1'b1) begin
            errors++; $display("FAIL wd_count_drain got %0d/%b exp 0/1", wbuf_count, wbuf_empty);
        end
        idle(1);
        drive_cycle(0, 1, 13'h040, 13'h040, 0, '0, '0);
        checks++; if (rd_valid !== 1'b1 || rd_data_lo !== 39'h0AA) begin
            errors++; $display("FAIL wd_read got %b/%h exp 1/0aa", rd_valid, rd_data_lo);
        end
        idle(1);
        checks++; if (rd_valid !== 1'b0 || rd_data_lo !== 39'h0AA) begin
            errors++; $display("FAIL wd_hold got %b/%h exp 0/0aa", rd_valid, rd_data_lo);
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++)
            drive_cycle(0, 1, 13'h088, 13'h088, 1, AW'(8 + 32 * k), DW'(39'h200 + k));
        checks++; if (wbuf_count !== 3'd4 || wr_ready !== 1'b0) begin
            errors++; $display("FAIL full_count got %0d/%b exp 4/0", wbuf_count, wr_ready);
        end
        drive_cycle(0, 1, 13'h088, 13'h088, 1, 13'h0A8, 39'h2FF);
        checks++; if (wbuf_count !== 3'd4) begin errors++; $display("FAIL full_drop got %0d exp 4", wbuf_count); end
        for (int k = 3; k >= 0; k--) begin
            idle(1);
            checks++; if (wbuf_count !== CW'(k)) begin
                errors++; $display("FAIL full_drain got %0d exp %0d", wbuf_count, k);
            end
        end
        drive_cycle(0, 1, 13'h068, 13'h068, 0, '0, '0);
        checks++; if (rd_data_lo !== 39'h203) begin errors++; $display("FAIL full_data got %h exp 203", rd_data_lo); end
        drive_cycle(0, 1, 13'h0A8, 13'h0A8, 0, '0, '0);
        checks++; if (mem_m.exists(word_of(13'h0A8))) begin
            errors++; $display("FAIL full_dropped_stored got 1 exp 0");
        end
    endtask

    task automatic test_forward();
        drive_cycle(0, 1, 13'h048, 13'h048, 1, 13'h008, 39'h111);
        drive_cycle(0, 1, 13'h048, 13'h048, 1, 13'h008, 39'h222);
        drive_cycle(0, 1, 13'h008, 13'h008, 0, '0, '0);
        checks++; if (rd_data_lo !== 39'h222 || wbuf_count !== 3'd2) begin
            errors++; $display("FAIL fwd_youngest got %h/%0d exp 222/2", rd_data_lo, wbuf_count);
        end
        idle(2);
        drive_cycle(0, 1, 13'h008, 13'h008, 0, '0, '0);
        checks++; if (rd_data_lo !== 39'h222 || wbuf_count !== 3'd0) begin
            errors++; $display("FAIL fwd_after_drain got %h/%0d exp 222/0", rd_data_lo, wbuf_count);
        end
        drive_cycle(0, 1, 13'h008, 13'h008, 1, 13'h008, 39'h333);
        checks++; if (rd_data_lo !== 39'h222) begin errors++; $display("FAIL fwd_same_cycle got %h exp 222", rd_data_lo); end
        drive_cycle(0, 1, 13'h008, 13'h008, 0, '0, '0);
        checks++; if (rd_data_lo !== 39'h333 || wbuf_count !== 3'd1) begin
            errors++; $display("FAIL fwd_next_cycle got %h/%0d exp 333/1", rd_data_lo, wbuf_count);
        end
        idle(1);
    endtask

    task automatic test_misaligned();
        drive_cycle(0, 0, '0, '0, 1, 13'h01C, 39'h1C1);
        drive_cycle(0, 0, '0, '0, 1, 13'h020, 39'h201);
        idle(1);
        drive_cycle(0, 0, '0, '0, 1, 13'h00C, 39'h0C3);
        drive_cycle(0, 1, 13'h01C, 13'h020, 0, '0, '0);
        checks++; if (rd_valid !== 1'b1 || rd_data_lo !== 39'h1C1 || rd_data_hi !== 39'h201) begin
            errors++; $display("FAIL mis_data got %b/%h/%h exp 1/1c1/201", rd_valid, rd_data_lo, rd_data_hi);
        end
        checks++; if (wbuf_count !== 3'd0) begin errors++; $display("FAIL mis_drain got %0d exp 0", wbuf_count); end
        drive_cycle(0, 1, 13'h00C, 13'h00C, 0, '0, '0);
        checks++; if (rd_data_lo !== 39'h0C3) begin errors++; $display("FAIL mis_bank3 got %h exp 0c3", rd_data_lo); end
    endtask

    task automatic test_freeze();
        drive_cycle(0, 0, '0, '0, 1, 13'h050, 39'h5A5);
        idle(1);
        drive_cycle(0, 1, 13'h050, 13'h050, 1, 13'h054, 39'h123);
        checks++; if (rd_data_lo !== 39'h5A5 || wbuf_count !== 3'd1) begin
            errors++; $display("FAIL frz_setup got %h/%0d exp 5a5/1", rd_data_lo, wbuf_count);
        end
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1, 1, 13'h040, 13'h040, 1, 13'h060, 39'h777);
            checks++; if (rd_valid !== 1'b1 || rd_data_lo !== 39'h5A5 || wbuf_count !== 3'd1 || wr_ready !== 1'b0) begin
                errors++; $display("FAIL frz_hold got %b/%h/%0d/%b exp 1/5a5/1/0", rd_valid, rd_data_lo, wbuf_count, wr_ready);
            end
        end
        idle(1);
        checks++; if (rd_valid !== 1'b0 || rd_data_lo !== 39'h5A5 || wbuf_count !== 3'd0) begin
            errors++; $display("FAIL frz_resume got %b/%h/%0d exp 0/5a5/0", rd_valid, rd_data_lo, wbuf_count);
        end
        drive_cycle(0, 1, 13'h054, 13'h054, 0, '0, '0);
        checks++; if (rd_data_lo !== 39'h123) begin errors++; $display("FAIL frz_after got %h exp 123", rd_data_lo); end
    endtask

    task automatic test_random();
        logic [AW-1:0] lo, hi, wa;
        for (int w = 0; w < 32; w++) drive_cycle(0, 0, '0, '0, 1, AW'(w * 4), DW'($urandom()));
        idle(2);
        for (int c = 0; c < 400; c++) begin
            lo = AW'($urandom_range(0, 31) * 4);
            hi = ($urandom_range(0, 1) == 1) ? lo : lo + AW'(4);
            wa = AW'($urandom_range(0, 31) * 4);
            drive_cycle($urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0, lo, hi,
                        $urandom_range(0, 1) == 1, wa, DW'({$urandom(), $urandom()}));
            checks++; if (rd_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", c, rd_valid, exp_valid); end
            if (lo_known) begin
                checks++; if (rd_data_lo !== exp_lo) begin errors++; $display("FAIL rnd_lo c%0d got %h exp %h", c, rd_data_lo, exp_lo); end
            end
            if (hi_known) begin
                checks++; if (rd_data_hi !== exp_hi) begin errors++; $display("FAIL rnd_hi c%0d got %h exp %h", c, rd_data_hi, exp_hi); end
            end
            checks++; if (int'(wbuf_count) != mq.size() || wbuf_empty !== (mq.size() == 0)) begin
                errors++; $display("FAIL rnd_count c%0d got %0d/%b exp %0d", c, wbuf_count, wbuf_empty, mq.size());
            end
            checks++; if (wr_ready !== (!freeze && mq.size() < WD)) begin
                errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, wr_ready, !freeze && mq.size() < WD);
            end
        end
        idle(WD + 1);
    endtask

    task automatic test_reset_mid_drain();
        for (int k = 0; k < 3; k++)
            drive_cycle(0, 1, 13'h088, 13'h088, 1, AW'(8 + 32 * k), DW'(39'h400 + k));
        checks++; if (wbuf_count !== 3'd3 || rd_valid !== 1'b1) begin
            errors++; $display("FAIL rst_setup got %0d/%b exp 3/1", wbuf_count, rd_valid);
        end
        rd_en = 1'b0; wr_valid = 1'b0;
        #2 rst_l = 1'b0;
        #1;
        checks++; if (wbuf_count !== 3'd0 || wbuf_empty !== 1'b1 || wr_ready !== 1'b1 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL rst_async got %0d/%b/%b/%b exp 0/1/1/0", wbuf_count, wbuf_empty, wr_ready, rd_valid);
        end
        model_reset();
        @(negedge clk);
        rst_l = 1'b1;
        idle(2);
        checks++; if (wbuf_count !== 3'd0 || rd_data_lo !== '0) begin
            errors++; $display("FAIL rst_discard got %0d/%h exp 0/0", wbuf_count, rd_data_lo);
        end
    endtask

    initial begin
        test_reset();
        test_write_drain();
        test_full();
        test_forward();
        test_misaligned();
        test_freeze();
        test_random();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_dccm_wbuf_mem.md
Name: lsu_dccm_wbuf_mem

Overview:
Parametrised banked DCCM data store with an in-order write buffer. Reads take bank priority. Buffered writes drain to a bank in any cycle when no read targets it. Reads that hit pending buffered writes are forwarded. Sits between the LSU DC1 address stage and DC2 data alignment, and adds freeze-hold of read data plus a drain/empty status for fences.

Parameters:
NUM_BANKS, 8, bank count; power of two, >=2; BANK_BITS = log2(NUM_BANKS)
BANK_DEPTH, 256, words per bank; power of two; INDEX_BITS = log2(BANK_DEPTH)
DATA_WIDTH, 39, stored word width (32 data + 7 ECC, opaque here)
WBUF_DEPTH, 4, write buffer entries, >=1
ADDR_WIDTH, 2+BANK_BITS+INDEX_BITS (derived), byte address width; bits [1:0] ignored

Ports:
clk  in  1  core clock
rst_l  in  1  asynchronous active-low reset
freeze  in  1  pipeline freeze; no bank access, outputs hold
rd_en  in  1  read request
rd_addr_lo  in  ADDR_WIDTH  low word address
rd_addr_hi  in  ADDR_WIDTH  high word address (misaligned second word; equals lo if aligned)
wr_valid  in  1  write request
wr_ready  out  1  buffer can accept (count < WBUF_DEPTH)
wr_addr  in  ADDR_WIDTH  write word address
wr_data  in  DATA_WIDTH  write word
rd_valid  out  1  read data valid (DC2)
rd_data_lo  out  DATA_WIDTH  word for rd_addr_lo
rd_data_hi  out  DATA_WIDTH  word for rd_addr_hi
wbuf_count  out  log2(WBUF_DEPTH)+1  occupied entries
wbuf_empty  out  1  count == 0

Behaviour:
- Reset (async, rst_l low): buffer empty; wbuf_count=0; wbuf_empty=1; wr_ready=1; rd_valid=0; rd_data_lo/hi=0. Bank contents undefined. Reset mid-drain discards all pending entries.
- Bank select: addr[2 +: BANK_BITS]. Index: addr[2+BANK_BITS +: INDEX_BITS].
- Read, accepted when rd_en & ~freeze:
  - Banks used are bank(lo), plus bank(hi) if it differs.
  - Latency 1: rd_valid=1 and rd_data_* valid the next cycle.
  - If bank(hi)==bank(lo) with a different index, hi is not read; rd_data_hi = rd_data_lo, and the LSU guarantees no such request.
- Freeze: rd_valid, rd_data_lo and rd_data_hi hold their values. No bank read/write, no drain, no enqueue (wr_ready=0). A read with freeze high is not accepted.
- No accepted read in a non-freeze cycle: rd_valid=0 next cycle; rd_data holds.
- Write enqueue: on wr_valid & wr_ready, the entry {addr, data} is pushed at the tail. wr_ready depends only on the registered count, so a full buffer does not accept a write even if it drains that cycle. wr_valid while not ready is dropped; the LSU must hold it.
- Drain: the head entry writes its bank in a cycle when ~freeze and its bank is not used by the accepted read that cycle. Count then decrements. Only the head drains, in order, at most one per cycle.
- Simultaneous enqueue and drain: count is unchanged; the head advances, the tail advances, and pointers wrap modulo WBUF_DEPTH.
- Forwarding:
  - For each read word, compare the word address against all valid entries at cycle N, including the head draining in N.
  - On one or more hits, data comes from the youngest matching entry, with priority over the bank.
  - A write enqueued in cycle N is not visible to a read in cycle N; it is visible from N+1.
- Same-cycle bank write + read of a different bank: independent.
- Two entries to the same address: both drain in order, and the final bank value is the younger one.
- Each bank access is clock-gated: enable = read-used | drain-write for that bank, gated by ~freeze.

Test Plan:
1. Reset with rst_l low mid-drain (count=3) -> count=0, wbuf_empty=1, wr_ready=1, rd_valid=0 immediately, asynchronously.
2. Write 0x0AA to addr 0x40 (bank 0, NUM_BANKS=8) with no reads; read 0x40 at cycle +3 -> drain at cycle +1, count 1->0, rd_data_lo=0x0AA one cycle after the read.
3. Enqueue 4 writes to bank 2 while reading bank 2 every cycle -> count=4, wr_ready=0, 5th write dropped; stop reads -> one drain per cycle, count 4,3,2,1,0.
4. Writes 0x111 then 0x222 to addr 0x08 are both buffered, and bank 2 is held busy by reads to addr 0x48 to block draining; read 0x08 -> rd_data_lo=0x222 (youngest forwarded). After the drain, read 0x08 -> 0x222.
5. Misaligned read, lo=0x1C (bank 7, index 0), hi=0x20 (bank 0, index 1) -> both banks read; lo/hi data correct next cycle; head entry targeting bank 3 still drains the same cycle.
6. Read returns 0x5A5, then freeze is held 3 cycles with rd_en=1 and wr_valid=1 -> rd_data_lo stays 0x5A5, rd_valid held, count unchanged, wr_ready=0. After unfreeze, normal operation resumes.
